// File: rtl/axis_flow_gate_pkg.sv
// Shared types for the AXI-Stream flow gate: state encoding and gating policy.
package axis_flow_gate_pkg;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // State the gate moves to once it is allowed to change (at a boundary).
  function automatic state_e gate_target(input logic enable, input logic hold);
    if (enable) begin
      return ST_PASS;
    end
    return hold ? ST_HOLD : ST_DRAIN;
  endfunction

endpackage

// File: rtl/axis_flow_gate_if.sv
// AXI-Stream bundle (data, last, valid, ready) with source/sink views.
interface axis_flow_gate_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered output stage plus one overflow entry.
module axis_skid_buffer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic             head_last_q, head_last_d, skid_last_q, skid_last_d;
  logic             push, pop;

  // Ready depends only on the occupancy register, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_last  = head_last_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_data_d = in_data;
          head_last_d = in_last;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = in_data;
          head_last_d = in_last;
        end else if (push) begin
          skid_data_d = in_data;
          skid_last_d = in_last;
          count_d     = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_data_d = skid_data_q;
          head_last_d = skid_last_q;
          count_d     = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Payload registers carry no reset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    head_data_q <= head_data_d;
    head_last_q <= head_last_d;
    skid_data_q <= skid_data_d;
    skid_last_q <= skid_last_d;
  end

endmodule

// File: rtl/axis_flow_gate.sv
// Stream gate: passes, holds off, or drains-and-counts traffic, switching
// only on packet (or beat) boundaries; output buffered by a skid stage.
module axis_flow_gate
  import axis_flow_gate_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int CNTR_WIDTH       = 32,
  parameter int PACKET_MODE      = 1,
  parameter int RESET_DRAIN      = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cfg_enable,
  input  logic                  cfg_hold,
  input  logic                  cfg_cnt_clr,
  axis_flow_gate_if.slave       s_axis,
  axis_flow_gate_if.master      m_axis,
  output logic [CNTR_WIDTH-1:0] sts_drop_cnt,
  output logic [1:0]            sts_state
);
  state_e                state_q, state_d;
  logic                  in_pkt_q, in_pkt_d;
  logic [CNTR_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                  buf_in_ready, buf_in_valid;
  logic                  accept, boundary;

  always_comb begin
    s_axis.tready = 1'b0;
    if (areset) begin
      s_axis.tready = (RESET_DRAIN != 0);
    end else begin
      case (state_q)
        ST_PASS:  s_axis.tready = buf_in_ready;
        ST_DRAIN: s_axis.tready = 1'b1;
        default:  s_axis.tready = 1'b0;
      endcase
    end
  end

  assign accept       = s_axis.tvalid && s_axis.tready;
  // Beats taken during reset or outside PASS never reach the buffer.
  assign buf_in_valid = s_axis.tvalid && (state_q == ST_PASS) && !areset;
  assign boundary     = (PACKET_MODE == 0) || !in_pkt_q;

  always_comb begin
    state_d    = state_q;
    in_pkt_d   = in_pkt_q;
    drop_cnt_d = drop_cnt_q;
    if (boundary) begin
      state_d = gate_target(cfg_enable, cfg_hold);
    end
    if (accept) begin
      in_pkt_d = !s_axis.tlast;
    end
    if (cfg_cnt_clr) begin
      drop_cnt_d = '0;
    end else if (accept && (state_q == ST_DRAIN) && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_HOLD;
      in_pkt_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_pkt_q   <= in_pkt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign sts_drop_cnt = drop_cnt_q;
  assign sts_state    = state_q;

  axis_skid_buffer #(
    .WIDTH(AXIS_TDATA_WIDTH)
  ) u_skid (
    .clk      (aclk),
    .srst     (areset),
    .in_data  (s_axis.tdata),
    .in_last  (s_axis.tlast),
    .in_valid (buf_in_valid),
    .in_ready (buf_in_ready),
    .out_data (m_axis.tdata),
    .out_last (m_axis.tlast),
    .out_valid(m_axis.tvalid),
    .out_ready(m_axis.tready)
  );

endmodule

// File: tb/tb_axis_flow_gate.sv
// Randomised scoreboard bench for axis_flow_gate against a queue-based model.
module tb_axis_flow_gate;
  import axis_flow_gate_pkg::*;

  localparam int DW   = 16;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cfg_enable, cfg_hold, cfg_cnt_clr;
  logic [CW-1:0] sts_drop_cnt;
  logic [1:0]    sts_state;

  axis_flow_gate_if #(.DATA_WIDTH(DW)) s_if ();
  axis_flow_gate_if #(.DATA_WIDTH(DW)) m_if ();

  axis_flow_gate #(
    .AXIS_TDATA_WIDTH(DW),
    .CNTR_WIDTH      (CW),
    .PACKET_MODE     (1),
    .RESET_DRAIN     (1)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .cfg_enable  (cfg_enable),
    .cfg_hold    (cfg_hold),
    .cfg_cnt_clr (cfg_cnt_clr),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .sts_drop_cnt(sts_drop_cnt),
    .sts_state   (sts_state)
  );

  initial forever #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;  // 0: always ready, 1: toggle every cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sink-side ready pattern.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (rdy_mode == 1) m_if.tready = ~m_if.tready;
      else               m_if.tready = 1'b1;
    end
  end

  // Reference model: beats pending delivery, gate state, packet flag, drop count.
  beat_t exp_q[$];
  int    m_state;
  bit    m_in_pkt;
  int    m_cnt;
  bit    model_ok = 1'b0;

  initial forever begin
    bit    exp_rdy, acc;
    beat_t b;
    @(negedge aclk);
    if (areset)             exp_rdy = 1'b1;
    else if (m_state == 0)  exp_rdy = (exp_q.size() < 2);
    else                    exp_rdy = (m_state == 1);
    if (areset || model_ok) check("s_tready", {31'd0, s_if.tready}, {31'd0, exp_rdy});
    if (model_ok) begin
      check("sts_state", {30'd0, sts_state}, m_state);
      check("sts_drop_cnt", {28'd0, sts_drop_cnt}, m_cnt);
      check("m_tvalid", {31'd0, m_if.tvalid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0 && m_if.tvalid) begin
        check("m_beat", {15'd0, m_if.tlast, m_if.tdata}, {15'd0, exp_q[0]});
      end
    end
    if (areset) begin
      exp_q.delete();
      m_in_pkt = 1'b0;
      m_cnt    = 0;
      m_state  = 2;
      model_ok = 1'b1;
    end else if (model_ok) begin
      acc = s_if.tvalid && exp_rdy;
      if (exp_q.size() > 0 && m_if.tready) begin
        b = exp_q.pop_front();
        $display("beat out data=0x%04h last=%0d", b.data, b.last);
      end
      if (acc && m_state == 0) exp_q.push_back({s_if.tlast, s_if.tdata});
      if (cfg_cnt_clr)                          m_cnt = 0;
      else if (acc && m_state == 1 && m_cnt < MAXC) m_cnt++;
      if (!m_in_pkt) m_state = cfg_enable ? 0 : (cfg_hold ? 2 : 1);
      if (acc) m_in_pkt = !s_if.tlast;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit ok = 1'b0;
    int n  = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = l;
    while (!ok && n < 200) begin
      @(negedge aclk);
      ok = s_if.tready;
      tick();
      n++;
    end
    s_if.tvalid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    areset      = 1'b1;
    cfg_enable  = 1'b0;
    cfg_hold    = 1'b1;
    cfg_cnt_clr = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    repeat (3) tick();
    areset = 1'b0;
    check("reset_state", {30'd0, sts_state}, {30'd0, ST_HOLD});
    check("reset_cnt", {28'd0, sts_drop_cnt}, 32'd0);
    check("reset_mvalid", {31'd0, m_if.tvalid}, 32'd0);

    // Back-to-back pass-through, one-cycle latency.
    cfg_enable = 1'b1;
    tick();
    check("to_pass", {30'd0, sts_state}, {30'd0, ST_PASS});
    for (int i = 1; i <= 16; i++) begin
      send(DW'(i), i == 16);
      check("latency", {15'd0, m_if.tvalid, m_if.tdata}, {15'd0, 1'b1, DW'(i)});
    end
    repeat (3) tick();

    // Toggling sink ready with random traffic and gaps.
    rdy_mode = 1;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(DW'($urandom), (i == 63) || ($urandom_range(0, 4) == 0));
    end
    rdy_mode = 0;
    repeat (5) tick();

    // Disable mid-packet: whole packet still delivered, then DRAIN.
    for (int i = 0; i < 8; i++) begin
      send(DW'(16'h0800 + i), i == 7);
      if (i == 1) begin
        cfg_enable = 1'b0;
        cfg_hold   = 1'b0;
      end
    end
    tick();
    check("after_tlast_state", {30'd0, sts_state}, {30'd0, ST_DRAIN});
    repeat (3) tick();

    // Drain counting and clear priority.
    for (int i = 0; i < 10; i++) send(DW'(16'h0100 + i), 1'b1);
    check("drop_cnt_10", {28'd0, sts_drop_cnt}, 32'd10);
    cfg_cnt_clr = 1'b1;
    send(16'h0200, 1'b1);
    cfg_cnt_clr = 1'b0;
    check("drop_cnt_clr", {28'd0, sts_drop_cnt}, 32'd0);
    check("drain_no_out", {31'd0, m_if.tvalid}, 32'd0);
    for (int i = 0; i < 20; i++) send(DW'($urandom), 1'b1);
    check("drop_cnt_sat", {28'd0, sts_drop_cnt}, MAXC);

    // HOLD with reset pulsed while a beat is waiting.
    cfg_hold = 1'b1;
    repeat (2) tick();
    check("hold_state", {30'd0, sts_state}, {30'd0, ST_HOLD});
    s_if.tvalid = 1'b1;
    s_if.tdata  = 16'hABCD;
    s_if.tlast  = 1'b0;
    repeat (3) tick();
    check("hold_tready", {31'd0, s_if.tready}, 32'd0);
    areset = 1'b1;
    @(negedge aclk);
    check("reset_drain_tready", {31'd0, s_if.tready}, 32'd1);
    tick();
    tick();
    areset = 1'b0;
    s_if.tvalid = 1'b0;
    check("post_reset_mvalid", {31'd0, m_if.tvalid}, 32'd0);
    check("post_reset_cnt", {28'd0, sts_drop_cnt}, 32'd0);

    // Reset mid-packet in PASS abandons the packet.
    cfg_enable = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) send(DW'(16'h0A00 + i), 1'b0);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("abandon_state", {30'd0, sts_state}, {30'd0, ST_HOLD});
    check("abandon_mvalid", {31'd0, m_if.tvalid}, 32'd0);
    tick();
    check("abandon_resume", {30'd0, sts_state}, {30'd0, ST_PASS});
    for (int i = 0; i < 4; i++) send(DW'(16'h0B00 + i), i == 3);
    repeat (5) tick();
    check("final_idle", {31'd0, m_if.tvalid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
